// File: rtl/hps_only_master_p2b_encoder.sv
// Avalon-ST packet-to-byte-stream encoder: turns each packet beat into a short
// marker/escape byte sequence, presented combinationally and stepped per transfer.
module hps_only_master_p2b_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_channel,
  input  logic       in_startofpacket,
  input  logic       in_endofpacket,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  localparam logic [7:0] SOP_BYTE  = 8'h7A;
  localparam logic [7:0] EOP_BYTE  = 8'h7B;
  localparam logic [7:0] CHAN_BYTE = 8'h7C;
  localparam logic [7:0] ESC_BYTE  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  // Item positions in the per-beat sequence; position 0 (channel marker) is
  // only ever the first item, so it is reached solely through STEP_START.
  localparam logic [2:0] P_CHAN_MARK = 3'd0;
  localparam logic [2:0] P_CHAN_ESC  = 3'd1;
  localparam logic [2:0] P_CHAN_VAL  = 3'd2;
  localparam logic [2:0] P_SOP       = 3'd3;
  localparam logic [2:0] P_EOP       = 3'd4;
  localparam logic [2:0] P_DATA_ESC  = 3'd5;
  localparam logic [2:0] P_DATA      = 3'd6;

  typedef enum logic [2:0] {
    STEP_START    = 3'd0,
    STEP_CHAN_ESC = 3'd1,
    STEP_CHAN_VAL = 3'd2,
    STEP_SOP      = 3'd3,
    STEP_EOP      = 3'd4,
    STEP_DATA_ESC = 3'd5,
    STEP_DATA     = 3'd6
  } step_t;

  step_t       step;
  step_t       step_nxt;
  logic        chan_sent;
  logic [7:0]  last_channel;

  logic        chan_special;
  logic        data_special;
  logic        need_chan;
  logic [6:0]  applicable;
  logic [2:0]  cur_pos;
  logic [2:0]  next_pos;
  logic [7:0]  cur_byte;
  logic        xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      step         <= STEP_START;
      chan_sent    <= 1'b0;
      last_channel <= 8'h00;
    end else begin
      step <= step_nxt;
      if (xfer && cur_pos == P_CHAN_VAL) begin
        chan_sent    <= 1'b1;
        last_channel <= in_channel;
      end
    end
  end

  // Applicable items depend only on the held beat and channel history, which do
  // not change before the channel value transfers, so positions stay consistent.
  always_comb begin
    chan_special = (in_channel >= SOP_BYTE) && (in_channel <= ESC_BYTE);
    data_special = (in_data >= SOP_BYTE) && (in_data <= ESC_BYTE);
    need_chan    = in_startofpacket && (!chan_sent || (in_channel != last_channel));
    applicable   = {1'b1, data_special, in_endofpacket, in_startofpacket,
                    need_chan, need_chan && chan_special, need_chan};

    cur_pos = P_DATA;
    if (step == STEP_START) begin
      for (int i = 6; i >= 0; i--) begin
        if (applicable[i]) cur_pos = 3'(i);
      end
    end else begin
      cur_pos = step;
    end

    next_pos = P_DATA;
    for (int i = 5; i >= 1; i--) begin
      if (applicable[i] && (3'(i) > cur_pos)) next_pos = 3'(i);
    end

    case (cur_pos)
      P_CHAN_MARK: cur_byte = CHAN_BYTE;
      P_CHAN_ESC:  cur_byte = ESC_BYTE;
      P_CHAN_VAL:  cur_byte = chan_special ? (in_channel ^ ESC_XOR) : in_channel;
      P_SOP:       cur_byte = SOP_BYTE;
      P_EOP:       cur_byte = EOP_BYTE;
      P_DATA_ESC:  cur_byte = ESC_BYTE;
      default:     cur_byte = data_special ? (in_data ^ ESC_XOR) : in_data;
    endcase

    out_valid = in_valid && !reset;
    out_data  = reset ? 8'h00 : cur_byte;
    xfer      = out_valid && out_ready;
    in_ready  = xfer && (cur_pos == P_DATA);

    step_nxt = step;
    if (xfer) begin
      step_nxt = (cur_pos == P_DATA) ? STEP_START : step_t'(next_pos);
    end
  end

endmodule

// File: tb/tb_hps_only_master_p2b_encoder.sv
// Self-checking bench: random and directed beats compared against a queue-based
// model that expands each beat into its expected byte sequence.
module tb_hps_only_master_p2b_encoder;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] in_channel;
  logic       in_startofpacket;
  logic       in_endofpacket;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  bit         m_chan_sent;
  logic [7:0] m_last_ch;
  bit         m_new_chan;

  hps_only_master_p2b_encoder dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_channel       (in_channel),
    .in_startofpacket (in_startofpacket),
    .in_endofpacket   (in_endofpacket),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic void pushEscaped(input logic [7:0] b);
    if (b >= 8'h7A && b <= 8'h7D) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(b ^ 8'h20);
    end else begin
      exp_q.push_back(b);
    end
  endfunction

  function automatic void buildExpected(input bit sop, input bit eop, input logic [7:0] ch, input logic [7:0] d);
    exp_q.delete();
    m_new_chan = sop && (!m_chan_sent || ch != m_last_ch);
    if (m_new_chan) begin
      exp_q.push_back(8'h7C);
      pushEscaped(ch);
    end
    if (sop) exp_q.push_back(8'h7A);
    if (eop) exp_q.push_back(8'h7B);
    pushEscaped(d);
  endfunction

  // mode 0: always ready, 1: random ready, 2: stalled for the first 3 cycles
  task automatic applyStimulus(input bit sop, input bit eop, input logic [7:0] ch, input logic [7:0] d,
                               input int mode, input int skip, input int abort_after);
    int idx;
    int xfers;
    int cyc;
    bit done;
    bit aborted;
    buildExpected(sop, eop, ch, d);
    idx = skip; xfers = 0; cyc = 0; done = 0; aborted = 0;
    while (!done && !aborted && cyc < 200) begin
      @(negedge clk);
      in_valid         = 1'b1;
      in_startofpacket = sop;
      in_endofpacket   = eop;
      in_channel       = ch;
      in_data          = d;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 9) < 7);
        default: out_ready = (cyc >= 3);
      endcase
      #1;
      checkOutput("out_valid", out_valid, 1);
      checkOutput("out_data", out_data, exp_q[idx]);
      checkOutput("in_ready", in_ready, (out_ready && idx == exp_q.size() - 1));
      @(posedge clk);
      cyc++;
      if (out_ready) begin
        xfers++;
        if (idx == exp_q.size() - 1) begin
          done = 1;
          if (m_new_chan) begin
            m_chan_sent = 1;
            m_last_ch   = ch;
          end
        end else begin
          idx++;
        end
        if (abort_after > 0 && xfers == abort_after) aborted = 1;
      end
    end
    if (!aborted) checkOutput("beat_done", done, 1);
  endtask

  task automatic idleCycle();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = $urandom_range(0, 1);
    #1;
    checkOutput("idle_out_valid", out_valid, 0);
    checkOutput("idle_in_ready", in_ready, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset            = 1'b1;
    in_valid         = 1'b1;
    out_ready        = 1'b1;
    in_startofpacket = 1'b1;
    in_endofpacket   = 1'b1;
    in_data          = 8'h55;
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_out_data", out_data, 8'h00);
    end
    @(negedge clk);
    reset       = 1'b0;
    in_valid    = 1'b0;
    m_chan_sent = 0;
    m_last_ch   = 8'h00;
  endtask

  function automatic logic [7:0] pickByte();
    logic [7:0] b;
    case ($urandom_range(0, 4))
      0:       b = 8'h00;
      1:       b = 8'h05;
      2:       b = 8'(8'h7A + $urandom_range(0, 3));
      default: b = 8'($urandom);
    endcase
    return b;
  endfunction

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 8'h00; in_channel = 8'h00;
    in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    m_chan_sent = 0; m_last_ch = 8'h00; m_new_chan = 0;

    doReset();
    applyStimulus(1, 1, 8'h00, 8'h41, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 8'h10, 0, 0, 0);
    applyStimulus(0, 1, 8'h00, 8'h7A, 0, 0, 0);
    applyStimulus(1, 1, 8'h7D, 8'h7B, 0, 0, 0);
    applyStimulus(0, 0, 8'h33, 8'h7D, 0, 0, 0);
    idleCycle();

    doReset();
    applyStimulus(1, 1, 8'h00, 8'h41, 2, 0, 0);

    doReset();
    applyStimulus(1, 1, 8'h05, 8'h33, 0, 0, 2);
    doReset();
    applyStimulus(1, 1, 8'h05, 8'h33, 0, 0, 0);

    applyStimulus(1, 0, 8'h7A, 8'h7C, 0, 0, 1);
    idleCycle();
    idleCycle();
    applyStimulus(1, 0, 8'h7A, 8'h7C, 1, 1, 0);

    for (int n = 0; n < 300; n++) begin
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                    pickByte(), pickByte(), 1, 0, 0);
      if ($urandom_range(0, 4) == 0) idleCycle();
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hps_only_master_p2b_encoder.md
HPS_ONLY_MASTER_P2B_ENCODER -- requirements
Module: hps_only_master_p2b_encoder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  Avalon-ST packet beat valid.
REQ-005 in_ready  output  1  beat consumed when in_valid && in_ready.
REQ-006 in_data  input  8  packet payload byte.
REQ-007 in_channel  input  8  channel of current beat; sampled only on startofpacket beats.
REQ-008 in_startofpacket  input  1  first beat of packet.
REQ-009 in_endofpacket  input  1  last beat of packet.
REQ-010 out_valid  output  1  encoded byte-stream valid.
REQ-011 out_ready  input  1  downstream accepts byte when out_valid && out_ready.
REQ-012 out_data  output  8  encoded byte.

Function
REQ-013 SHALL encode each input beat as an ordered byte sequence: [CHAN 0x7C, channel byte] if needed; [SOP 0x7A] if in_startofpacket; [EOP 0x7B] if in_endofpacket; payload byte.
REQ-014 SHALL emit the channel pair only on SOP beats, and only if no channel has been sent since reset or in_channel differs from the last channel sent.
REQ-015 SHALL escape any channel or payload byte in 0x7A..0x7D as two bytes: 0x7D, then byte XOR 0x20; marker bytes are never escaped.
REQ-016 Sequence length SHALL be 1..7 bytes; a beat with SOP, EOP, new special channel and special data yields 0x7C,0x7D,ch^0x20,0x7A,0x7B,0x7D,d^0x20.
REQ-017 out_valid and out_data SHALL be combinational from in_valid, the held input beat and the step register; zero-cycle latency from in_valid to first byte.
REQ-018 Step register states: START, CHAN_ESC, CHAN_VAL, SOP, EOP, DATA_ESC, DATA; START presents the first applicable byte of the sequence.
REQ-019 Step SHALL advance to the next applicable item only on an output transfer (out_valid && out_ready); otherwise it holds and out_data stays stable.
REQ-020 in_ready SHALL be high only in the cycle the last byte of the beat's sequence transfers; step then returns to START.
REQ-021 out_valid SHALL equal in_valid outside reset; the input beat is held stable by upstream while in_valid && !in_ready.
REQ-022 last_channel register and chan_sent flag SHALL update when the channel value byte (escaped or plain) transfers.
REQ-023 If in_valid drops mid-sequence (protocol violation), step SHALL hold; no byte is emitted until in_valid returns.
REQ-024 A SOP beat while a packet is open SHALL be encoded normally; no error state exists.

Reset
REQ-025 While reset is high: out_valid=0, in_ready=0, out_data=0x00, step=START, chan_sent=0, last_channel=0x00.
REQ-026 Reset mid-sequence SHALL abandon the beat; the first SOP after reset always emits the channel pair.
REQ-027 First beat SHALL be accepted in the cycle after reset deasserts, at the earliest.

Verification
REQ-028 After reset, out_ready=1, beat {SOP,EOP,ch=0x00,d=0x41} -> out 0x7C,0x00,0x7A,0x7B,0x41 on 5 consecutive cycles; in_ready high in cycle 5 only.
REQ-029 Next packet ch=0x00: beat {SOP,d=0x10}, beat {EOP,d=0x7A} -> 0x7A,0x10 then 0x7B,0x7D,0x5A; no channel pair.
REQ-030 Packet ch=0x7D, {SOP,EOP,d=0x7B} -> 0x7C,0x7D,0x5D,0x7A,0x7B,0x7D,0x5B; last_channel=0x7D.
REQ-031 out_ready=0 for 3 cycles after first byte of REQ-028 sequence -> out_data held 0x7C, out_valid=1, in_ready=0, step unchanged; sequence resumes intact.
REQ-032 Reset asserted after 0x7C,0x05 transferred -> outputs reset values; next SOP ch=0x05 re-emits 0x7C,0x05.
REQ-033 Mid-packet beat d=0x7D, no SOP/EOP -> 0x7D,0x5D; in_ready high on second byte.
